// File: rtl/fractal_pkg.sv
// Shared types and helpers for the fractal display path: frame geometry,
// frame_writer FSM encoding, write-buffer entry layout and the colour map.
package fractal_pkg;

  localparam int DEF_NUM_COLUMNS = 99;
  localparam int DEF_NUM_ROWS    = 66;
  localparam int FRAME_PIXELS    = DEF_NUM_COLUMNS * DEF_NUM_ROWS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } fw_state_e;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  colour;
    logic        last;
  } fb_entry_t;

  // RGB332 with red in the low bits; escaping pixels are never pure black.
  function automatic logic [7:0] iter_to_rgb332(input logic [31:0] iter,
                                                input logic [31:0] max_iter);
    logic [7:0] c;
    if (iter >= max_iter) return 8'h00;
    c = {iter[7:6], iter[5:3], iter[2:0]};
    return (c == 8'h00) ? 8'h01 : c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; simultaneous push/pop when full is legal.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && (count_q == (AW+1)'(DEPTH)) && !pop_i));

endmodule

// File: rtl/frame_writer.sv
// Pairs solver read tags with returned iteration counts, converts them to
// framebuffer writes through a backpressured buffer, and flags frame completion.
module frame_writer
  import fractal_pkg::*;
#(
  parameter int NUM_SOLVERS = 7,
  parameter int NUM_COLUMNS = 99,
  parameter int NUM_ROWS    = 66,
  parameter int ITER_W      = 16,
  parameter int MAX_ITER    = 1000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [5:0]        req_solver_id,
  input  logic [18:0]       req_addr,
  input  logic              req_last,
  input  logic [ITER_W-1:0] rd_data,
  output logic              stall,
  output logic              fb_wr_en,
  input  logic              fb_ready,
  output logic [18:0]       fb_wr_addr,
  output logic [7:0]        fb_wr_data,
  output logic              frame_done,
  output logic              busy
);
  localparam int PIXELS = NUM_COLUMNS * NUM_ROWS;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [2:1]    vld_q;
  logic [5:0]    s1_id_q;
  logic [18:0]   s1_addr_q;
  logic          s1_last_q;
  logic [18:0]   s2_pix_q;
  logic          s2_drop_q, s2_last_q;
  logic          stall_q, pend_q;
  fw_state_e     state_q;
  logic [31:0]   pix_full;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty, push, pop, drained, push_last, pop_last, drop_last;
  fb_entry_t     push_entry, head;

  // Kept 32 bits wide so out-of-range solver addresses cannot wrap into the frame.
  assign pix_full = 32'(s1_addr_q) * 32'(NUM_SOLVERS) + 32'(s1_id_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      s1_id_q   <= '0;
      s1_addr_q <= '0;
      s1_last_q <= 1'b0;
      s2_pix_q  <= '0;
      s2_drop_q <= 1'b0;
      s2_last_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      vld_q     <= {vld_q[1], req_valid};
      s1_id_q   <= req_solver_id;
      s1_addr_q <= req_addr;
      s1_last_q <= req_last;
      s2_pix_q  <= pix_full[18:0];
      s2_drop_q <= (pix_full >= 32'(PIXELS));
      s2_last_q <= s1_last_q;
      stall_q   <= (32'(fifo_cnt) + 32'(vld_q[1]) + 32'(vld_q[2])) >= 32'(FIFO_DEPTH - 2);
    end
  end

  assign push       = vld_q[2] && !s2_drop_q;
  assign push_entry = '{addr:   s2_pix_q,
                        colour: iter_to_rgb332(32'(rd_data), 32'(MAX_ITER)),
                        last:   s2_last_q};

  sync_fifo #(.WIDTH($bits(fb_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign fb_wr_en   = !fifo_empty;
  assign pop        = fb_wr_en && fb_ready;
  assign fb_wr_addr = fb_wr_en ? head.addr   : '0;
  assign fb_wr_data = fb_wr_en ? head.colour : '0;
  assign stall      = stall_q;

  // "drained" means the buffer is empty once this edge's pop (if any) lands.
  assign drained    = (fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop);
  assign push_last  = push && s2_last_q;
  assign pop_last   = pop && head.last;
  assign drop_last  = vld_q[2] && s2_drop_q && s2_last_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:   if (req_valid) state_q <= S_STREAM;
        S_STREAM: begin
          if (push_last) state_q <= S_DRAIN;
          else if (drop_last) begin
            state_q <= drained ? S_DONE : S_DRAIN;
            pend_q  <= !drained;
          end
        end
        S_DRAIN: begin
          if (pop_last || ((pend_q || drop_last) && drained)) begin
            state_q <= S_DONE;
            pend_q  <= 1'b0;
          end else if (drop_last) pend_q <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          pend_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frame_done = (state_q == S_DONE);
  assign busy       = (state_q == S_STREAM) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: solver model with 2-cycle read latency,
// expected writes queued at request time and matched as writes are accepted.
module tb_frame_writer;
  import fractal_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [5:0]  req_solver_id = '0;
  logic [18:0] req_addr = '0;
  logic        req_last = 1'b0;
  logic [15:0] rd_data = '0;
  logic        fb_ready = 1'b1;
  logic        stall, fb_wr_en, frame_done, busy;
  logic [18:0] fb_wr_addr;
  logic [7:0]  fb_wr_data;

  logic [15:0] req_iter = '0;
  logic [15:0] d1 = '0;

  int total = 0, bad = 0, writes = 0, done_cnt = 0, dup_cnt = 0, cyc = 0, ready_mode = 0;
  bit stall_seen = 0;
  bit seen [0:8191];
  logic [26:0] sb_q [$];

  always #5 clock = ~clock;

  frame_writer dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_solver_id(req_solver_id),
    .req_addr(req_addr), .req_last(req_last), .rd_data(rd_data), .stall(stall),
    .fb_wr_en(fb_wr_en), .fb_ready(fb_ready), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .frame_done(frame_done), .busy(busy)
  );

  // Solver model: data for a read appears two cycles after the request.
  always @(posedge clock) begin
    d1      <= req_valid ? req_iter : 16'hDEAD;
    rd_data <= d1;
  end

  always @(negedge clock) begin
    if (reset && fb_wr_en && fb_ready) begin
      logic [26:0] exp;
      writes++;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write addr=%0d data=%h", fb_wr_addr, fb_wr_data);
      end else begin
        exp = sb_q.pop_front();
        if ({fb_wr_addr, fb_wr_data} !== exp) begin
          bad++;
          $display("FAIL sb_write got addr=%0d data=%h exp addr=%0d data=%h",
                   fb_wr_addr, fb_wr_data, exp[26:8], exp[7:0]);
        end
      end
      if (fb_wr_addr < 19'd8192) begin
        if (seen[fb_wr_addr]) dup_cnt++;
        seen[fb_wr_addr] = 1'b1;
      end
    end
    if (frame_done) done_cnt++;
    if (stall) stall_seen = 1'b1;
  end

  function automatic logic [7:0] exp_col(input int iter);
    logic [31:0] v;
    v = iter;
    if (iter >= 1000) return 8'h00;
    return (v[7:0] == 8'h00) ? 8'h01 : v[7:0];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    req_valid = 1'b0;
    req_last  = 1'b0;
    case (ready_mode)
      0:       fb_ready = 1'b1;
      1:       fb_ready = (cyc % 3 == 0);
      default: fb_ready = 1'b0;
    endcase
  endtask

  task automatic issue(input int id, input int addr, input int iter, input bit last,
                       input logic [7:0] col);
    int idx;
    idx = addr * 7 + id;
    req_valid     = 1'b1;
    req_solver_id = 6'(id);
    req_addr      = 19'(addr);
    req_iter      = 16'(iter);
    req_last      = last;
    if (idx < FRAME_PIXELS) sb_q.push_back({19'(idx), col});
  endtask

  task automatic wait_stall_clear();
    int g;
    g = 0;
    while (stall && g < 100) begin step(); g++; end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({stall, fb_wr_en, fb_wr_addr, fb_wr_data, frame_done, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {stall, fb_wr_en, fb_wr_addr, fb_wr_data, frame_done, busy});
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    step();
    issue(3, 10, 5, 1'b0, 8'h05);
    step();
    step();
    total++;
    if (fb_wr_en !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", fb_wr_en); end
    step();
    total++;
    if ({fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b1, 19'd73, 8'h05}) begin
      bad++;
      $display("FAIL single_n3 got en=%b addr=%0d data=%h exp en=1 addr=73 data=05",
               fb_wr_en, fb_wr_addr, fb_wr_data);
    end
    repeat (2) step();
  endtask

  task automatic test_colour_back_to_back();
    int iters [6] = '{1000, 999, 256, 8, 0, 5000};
    logic [7:0] cols [6] = '{8'h00, 8'hE7, 8'h01, 8'h08, 8'h01, 8'h00};
    int w0;
    w0 = writes;
    for (int k = 0; k < 6; k++) begin
      issue(k, 100 + k, iters[k], 1'b0, cols[k]);
      step();
    end
    repeat (3) step();
    total++;
    if (writes - w0 != 6) begin
      bad++;
      $display("FAIL colour_throughput got=%0d writes exp=6", writes - w0);
    end
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL colour_sb_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_full_frame();
    int w0, d0, g, n, it;
    w0 = writes; d0 = done_cnt; dup_cnt = 0;
    for (int i = 0; i < 8192; i++) seen[i] = 1'b0;
    for (int a = 0; a < 934; a++) begin
      for (int id = 0; id < 7; id++) begin
        wait_stall_clear();
        it = int'($urandom_range(0, 1100));
        issue(id, a, it, (a == 933 && id == 6), exp_col(it));
        step();
      end
    end
    g = 0;
    while (done_cnt == d0 && g < 50) begin step(); g++; end
    total++;
    if (done_cnt == d0) begin bad++; $display("FAIL frame_done_timeout got=0 exp=1"); end
    repeat (3) step();
    n = 0;
    for (int i = 0; i < FRAME_PIXELS; i++) if (seen[i]) n++;
    total++;
    if (writes - w0 != 6534) begin bad++; $display("FAIL frame_writes got=%0d exp=6534", writes - w0); end
    total++;
    if (n != 6534 || dup_cnt != 0) begin
      bad++;
      $display("FAIL frame_coverage got unique=%0d dup=%0d exp unique=6534 dup=0", n, dup_cnt);
    end
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL frame_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    int d0, g, it;
    d0 = done_cnt; stall_seen = 1'b0; ready_mode = 1;
    for (int k = 0; k < 60; k++) begin
      wait_stall_clear();
      it = int'($urandom_range(0, 1100));
      issue(int'($urandom_range(0, 6)), int'($urandom_range(0, 900)), it, (k == 59), exp_col(it));
      step();
    end
    g = 0;
    while (done_cnt == d0 && g < 500) begin step(); g++; end
    ready_mode = 0;
    repeat (3) step();
    total++;
    if (!stall_seen) begin bad++; $display("FAIL bp_stall got=0 exp=1"); end
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL bp_sb_left got=%0d exp=0", sb_q.size()); end
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL bp_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_dropped_tail();
    int w0, d0, g;
    w0 = writes; d0 = done_cnt;
    issue(6, 933, 77, 1'b1, 8'h00);
    step();
    g = 0;
    while (done_cnt == d0 && g < 20) begin step(); g++; end
    repeat (3) step();
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL drop_done got=%0d exp=1", done_cnt - d0); end
    total++;
    if (writes != w0) begin bad++; $display("FAIL drop_writes got=%0d exp=0", writes - w0); end
  endtask

  task automatic test_reset_midframe();
    int w0;
    ready_mode = 2;
    step();
    for (int k = 0; k < 5; k++) begin
      issue(k, 20, 40 + k, 1'b0, exp_col(40 + k));
      step();
    end
    repeat (3) step();
    total++;
    if ({fb_wr_en, busy} !== 2'b11) begin
      bad++;
      $display("FAIL midreset_queued got en=%b busy=%b exp en=1 busy=1", fb_wr_en, busy);
    end
    reset = 1'b0;
    #1;
    sb_q.delete();
    total++;
    if ({stall, fb_wr_en, fb_wr_addr, fb_wr_data, frame_done, busy} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h exp=0",
               {stall, fb_wr_en, fb_wr_addr, fb_wr_data, frame_done, busy});
    end
    step();
    step();
    reset = 1'b1;
    ready_mode = 0;
    w0 = writes;
    repeat (10) step();
    total++;
    if (writes != w0 || fb_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL midreset_after got writes=%0d en=%b exp writes=0 en=0", writes - w0, fb_wr_en);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_colour_back_to_back();
    test_full_frame();
    test_backpressure();
    test_dropped_tail();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
